// File: rtl/alu_seq.sv
// Registered, handshaked ALU for the multicycle datapath.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (opcode 1010).
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Ovf,
  output logic             Err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_SLL  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_MUL  = 4'b1010,
    OP_NOR  = 4'b1100
  } op_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_ovf;
  logic             r_err;

  logic             w_accept;
  logic             w_load;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_err;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW:0]     r_cnt;
  logic             w_is_mul;
  logic             w_start;
  logic             w_step;
  logic             w_finish;
`endif

  assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_state == S_DONE);
  assign ALUOut    = r_alu_out;
  assign Zero      = r_zero;
  assign Ovf       = r_ovf;
  assign Err       = r_err;

  // Single-cycle result datapath, evaluated on the raw inputs at accept time.
  always_comb begin
    w_res   = '0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    w_sum   = A + B;
    w_diff  = A - B;
    w_shamt = B[SHW-1:0];
`ifdef ALU_SEQ_MUL_EN
    w_is_mul = 1'b0;
`endif
    case (ALUctl)
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_NOR:  w_res = ~(A | B);
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (A[WIDTH-1] == B[WIDTH-1]) & (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (A[WIDTH-1] != B[WIDTH-1]) & (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  w_res = A << w_shamt;
      OP_SRL:  w_res = A >> w_shamt;
      OP_SRA:  w_res = $signed(A) >>> w_shamt;
`ifdef ALU_SEQ_MUL_EN
      OP_MUL:  w_is_mul = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // DONE with out_ready behaves exactly like IDLE when a new op arrives.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    w_start  = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (w_is_mul) begin
            w_start     = 1'b1;
            w_state_nxt = S_BUSY;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = S_DONE;
          end
`else
          w_load      = 1'b1;
          w_state_nxt = S_DONE;
`endif
        end else if ((r_state == S_DONE) && out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_BUSY: begin
        if (r_cnt == CNT_LAST) begin
          w_finish    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_out <= '0;
      r_zero    <= 1'b1;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_load) begin
      r_alu_out <= w_res;
      r_zero    <= (w_res == '0);
      r_ovf     <= w_ovf;
      r_err     <= w_err;
`ifdef ALU_SEQ_MUL_EN
    end else if (w_finish) begin
      r_alu_out <= r_acc;
      r_zero    <= (r_acc == '0);
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
`endif
    end
  end

`ifdef ALU_SEQ_MUL_EN
  // WIDTH shift-add steps, then one extra cycle to register the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_start) begin
      r_mcand  <= A;
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + (SHW+1)'(1);
    end
  end
`endif

endmodule
